// File: rtl/sha256_msg_expander.sv
// SHA-256 message expander (ME side of ME->MC): loads 16 words, streams W[0..63], then holds SEND.
// Latency: COMPUTE begins the cycle after the 16th accepted word; one W word per cycle after that.
// Backpressure: ready_out is high only in LOAD, where valid_in gaps stall without limit; the output side has none.
// Optional build macro ME_ERR_CHK_EN enables the sticky protocol error flag err_out.
module sha256_msg_expander #(
    parameter int DATA_WIDTH  = 32,
    parameter int SEND_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  start_out,
    output logic [1:0]            FSM_state_out,
    output logic [5:0]            round_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done_out,
    output logic                  err_out
);

    localparam int SCW = $clog2(SEND_CYCLES + 1);
    localparam logic [SCW-1:0] SEND_LAST = SCW'(SEND_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_LOAD    = 2'b01,
        S_COMPUTE = 2'b10,
        S_SEND    = 2'b11
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_win [16];
    logic [DATA_WIDTH-1:0] w_win_nxt [16];
    logic [3:0]            r_load_cnt;
    logic [5:0]            r_round;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [SCW-1:0]        r_send_cnt;
    logic                  w_accept;
    logic                  w_last_word;
    logic                  w_last_round;
    logic                  w_send_last;
    logic [DATA_WIDTH-1:0] w_wnew;

    // Small sigma functions of the schedule recurrence.
    function automatic logic [DATA_WIDTH-1:0] f_sigma0(input logic [DATA_WIDTH-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_sigma1(input logic [DATA_WIDTH-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign ready_out     = (r_state == S_LOAD);
    assign start_out     = start_in && (r_state == S_IDLE);
    assign FSM_state_out = r_state;
    assign round_out     = r_round;
    assign data_out      = r_data_out;
    assign w_accept      = valid_in && (r_state == S_LOAD);
    assign w_last_word   = w_accept && (r_load_cnt == 4'd15);
    assign w_last_round  = (r_state == S_COMPUTE) && (r_round == 6'd63);
    assign w_send_last   = (r_state == S_SEND) && (r_send_cnt == SEND_LAST);
    assign done_out      = w_send_last;
    // Window holds W[t..t+15]; the new word is W[t+16].
    assign w_wnew        = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];

    // Next-state logic for the IDLE/LOAD/COMPUTE/SEND sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start_in)     w_state_nxt = S_LOAD;
            S_LOAD:    if (w_last_word)  w_state_nxt = S_COMPUTE;
            S_COMPUTE: if (w_last_round) w_state_nxt = S_SEND;
            S_SEND:    if (w_send_last)  w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    // Window shifts down on every accepted word and on every COMPUTE cycle.
    always_comb begin
        w_win_nxt = r_win;
        if (w_accept || (r_state == S_COMPUTE)) begin
            for (int i = 0; i < 15; i++) begin
                w_win_nxt[i] = r_win[i + 1];
            end
            w_win_nxt[15] = w_accept ? data_in : w_wnew;
        end
    end

    // State, window, counters and the registered W output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_win      <= '{default: '0};
            r_load_cnt <= '0;
            r_round    <= '0;
            r_data_out <= '0;
            r_send_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_win   <= w_win_nxt;
            if ((r_state == S_IDLE) && start_in) begin
                r_load_cnt <= '0;
            end else if (w_accept) begin
                r_load_cnt <= r_load_cnt + 4'd1;
            end
            case (w_state_nxt)
                S_COMPUTE: r_round <= (r_state == S_COMPUTE) ? r_round + 6'd1 : 6'd0;
                S_SEND:    r_round <= 6'd63;
                default:   r_round <= 6'd0;
            endcase
            // The word entering slot 0 is exactly W[t] for the next COMPUTE cycle.
            r_data_out <= (w_state_nxt == S_COMPUTE) ? w_win_nxt[0] : '0;
            r_send_cnt <= ((r_state == S_SEND) && !w_send_last) ? r_send_cnt + 1'b1 : '0;
        end
    end

`ifdef ME_ERR_CHK_EN
    logic r_err;
    assign err_out = r_err;

    // Sticky protocol error; only an accepted start (or reset) clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && start_in) begin
            r_err <= 1'b0;
        end else if ((start_in && (r_state != S_IDLE)) ||
                     (valid_in && ((r_state == S_COMPUTE) || (r_state == S_SEND)))) begin
            r_err <= 1'b1;
        end
    end
`else
    assign err_out = 1'b0;
`endif

endmodule
